branch_target_buffer: RTL and testbench

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer_pkg.sv | 24 ++
 rtl/branch_target_buffer_lru_counter.sv | 55 +++++
 rtl/defines.vh | 14 +
 rtl/branch_target_buffer.sv | 128 ++++++++++++
 tb/tb_branch_target_buffer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Common types and helpers for the branch target buffer and its victim selector.
`include "defines.vh"

package branch_target_buffer_pkg;

  localparam int LINE_NUM = `BTB_LINE_NUM;
  localparam int IDX_W    = `BTB_LINE_SIZE;

  typedef logic [1:0]       ctr_t;
  typedef logic [IDX_W-1:0] idx_t;

  // Next value of a two-bit saturating predictor given the resolved outcome.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != `BTB_STRONG_T) r = c + 2'd1;
    end else begin
      if (c != `BTB_STRONG_NT) r = c - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_target_buffer_lru_counter.sv
// True-LRU victim selector: each line holds a distinct age rank, the line
// with the highest rank is the least recently accessed and is the victim.
`include "defines.vh"

module lru_counter
  import branch_target_buffer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hit,
  input  idx_t hit_line,
  output idx_t lru_line
);

  idx_t age_q [LINE_NUM];
  idx_t age_d [LINE_NUM];
  idx_t victim;
  idx_t access_idx;

  // Victim is the single line whose age rank is the oldest possible value.
  always_comb begin
    victim = '0;
    for (int i = 0; i < LINE_NUM; i++) begin
      if (age_q[i] == idx_t'(LINE_NUM - 1)) victim = idx_t'(i);
    end
  end

  assign lru_line   = victim;
  assign access_idx = hit ? hit_line : victim;

  // Accessed line becomes youngest; every line younger than it ages by one.
  always_comb begin
    age_d = age_q;
    if (en) begin
      for (int i = 0; i < LINE_NUM; i++) begin
        if (idx_t'(i) == access_idx) begin
          age_d[i] = '0;
        end else if (age_q[i] < age_q[access_idx]) begin
          age_d[i] = age_q[i] + idx_t'(1);
        end
      end
    end
  end

  // Reset ranks make line 0 the first victim, then line 1, and so on.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINE_NUM; i++) age_q[i] <= idx_t'(LINE_NUM - 1 - i);
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/defines.vh
// Shared sizing and predictor-counter encodings for the branch target buffer.
`ifndef BTB_DEFINES_VH
`define BTB_DEFINES_VH

`define BTB_LINE_NUM  8
`define BTB_LINE_SIZE 3

// Two-bit saturating counter encodings; bit 1 is the taken prediction.
`define BTB_STRONG_NT 2'b00
`define BTB_WEAK_NT   2'b01
`define BTB_WEAK_T    2'b10
`define BTB_STRONG_T  2'b11

`endif

// File: rtl/branch_target_buffer.sv
// Fully associative 8-line branch target buffer with 2-bit saturating
// direction counters and LRU replacement. Lookups are purely combinational
// on current state, so a same-cycle update is never visible to the lookup.
`include "defines.vh"

module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] lookup_pc,
  output logic                  predict_hit,
  output logic                  predict_taken,
  output logic [DATA_WIDTH-1:0] predict_target,
  input  logic                  update_en,
  input  logic [DATA_WIDTH-1:0] update_pc,
  input  logic                  update_taken,
  input  logic [DATA_WIDTH-1:0] update_target
);

  localparam int TAG_W = DATA_WIDTH - 2;

  logic [LINE_NUM-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q    [LINE_NUM];
  logic [TAG_W-1:0]      tag_d    [LINE_NUM];
  logic [DATA_WIDTH-1:0] target_q [LINE_NUM];
  logic [DATA_WIDTH-1:0] target_d [LINE_NUM];
  ctr_t                  ctr_q    [LINE_NUM];
  ctr_t                  ctr_d    [LINE_NUM];

  logic                  look_hit;
  idx_t                  look_idx;
  logic                  upd_hit;
  idx_t                  upd_idx;
  logic                  upd_fire;
  logic                  lru_en;
  idx_t                  lru_line;
  logic [DATA_WIDTH-1:0] pc_plus4;

  // Byte-offset bits are not part of the tag.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

  // Lookup match; scanning downwards leaves the lowest matching index.
  always_comb begin
    look_hit = 1'b0;
    look_idx = '0;
    for (int i = LINE_NUM - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == lookup_pc[DATA_WIDTH-1:2])) begin
        look_hit = 1'b1;
        look_idx = idx_t'(i);
      end
    end
  end

  // Update match against the same pre-update state.
  always_comb begin
    upd_hit = 1'b0;
    upd_idx = '0;
    for (int i = LINE_NUM - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == update_pc[DATA_WIDTH-1:2])) begin
        upd_hit = 1'b1;
        upd_idx = idx_t'(i);
      end
    end
  end

  // Prediction outputs; fall-through PC wraps naturally at DATA_WIDTH bits.
  always_comb begin
    pc_plus4       = lookup_pc + DATA_WIDTH'(4);
    predict_hit    = look_hit;
    predict_taken  = look_hit & ctr_q[look_idx][1];
    predict_target = predict_taken ? target_q[look_idx] : pc_plus4;
  end

  assign upd_fire = en & update_en;
  // LRU moves on a training hit or on an allocation, never on a not-taken miss.
  assign lru_en   = upd_fire & (upd_hit | update_taken);

  lru_counter u_lru (
    .clk      (clk),
    .rst      (rst),
    .en       (lru_en),
    .hit      (upd_hit),
    .hit_line (upd_idx),
    .lru_line (lru_line)
  );

  // Next-state: train an existing line, or allocate the LRU line on a taken miss.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_fire) begin
      if (upd_hit) begin
        ctr_d[upd_idx] = ctr_next(ctr_q[upd_idx], update_taken);
        if (update_taken) target_d[upd_idx] = update_target;
      end else if (update_taken) begin
        valid_d[lru_line]  = 1'b1;
        tag_d[lru_line]    = update_pc[DATA_WIDTH-1:2];
        target_d[lru_line] = update_target;
        ctr_d[lru_line]    = `BTB_WEAK_T;
      end
    end
  end

  // State registers; reset wins over any update in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LINE_NUM; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= `BTB_STRONG_NT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer.
module tb_branch_target_buffer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] lookup_pc;
  logic        predict_hit;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;

  int total;
  int bad;

  branch_target_buffer #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .lookup_pc      (lookup_pc),
    .predict_hit    (predict_hit),
    .predict_taken  (predict_taken),
    .predict_target (predict_target),
    .update_en      (update_en),
    .update_pc      (update_pc),
    .update_taken   (update_taken),
    .update_target  (update_target)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    update_en     = 1'b1;
    update_pc     = pc;
    update_taken  = taken;
    update_target = tgt;
    @(posedge clk); #1;
    update_en     = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_pc = pc;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    // reset asserted together with a taken update must leave no line valid
    rst = 1'b1; update_en = 1'b1; update_pc = 32'h100; update_taken = 1'b1; update_target = 32'h200;
    @(posedge clk); #1;
    rst = 1'b0; update_en = 1'b0;
    look(32'h100);
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b0, 1'b0, 32'h104}) begin
      bad++; $display("FAIL reset_lookup: got hit=%0b taken=%0b tgt=%h want 0 0 00000104", predict_hit, predict_taken, predict_target);
    end
    look(32'hFFFF_FFFC);
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b0, 1'b0, 32'h0}) begin
      bad++; $display("FAIL wrap_plus4: got hit=%0b taken=%0b tgt=%h want 0 0 00000000", predict_hit, predict_taken, predict_target);
    end
  endtask

  task automatic test_counter();
    do_reset();
    upd(32'h100, 1'b1, 32'h200);
    look(32'h100);
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b1, 1'b1, 32'h200}) begin
      bad++; $display("FAIL alloc_hit: got hit=%0b taken=%0b tgt=%h want 1 1 00000200", predict_hit, predict_taken, predict_target);
    end
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0);
    look(32'h100);
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b1, 1'b0, 32'h104}) begin
      bad++; $display("FAIL ctr_zero: got hit=%0b taken=%0b tgt=%h want 1 0 00000104", predict_hit, predict_taken, predict_target);
    end
    // saturate at 0: one more NT, then two taken needed to reach 2 again
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b1, 32'h240);
    look(32'h100);
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b1, 1'b0, 32'h104}) begin
      bad++; $display("FAIL ctr_sat_low: got hit=%0b taken=%0b tgt=%h want 1 0 00000104", predict_hit, predict_taken, predict_target);
    end
    upd(32'h100, 1'b1, 32'h240);
    look(32'h100);
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b1, 1'b1, 32'h240}) begin
      bad++; $display("FAIL target_update: got hit=%0b taken=%0b tgt=%h want 1 1 00000240", predict_hit, predict_taken, predict_target);
    end
    // counter 2 -> 3 -> stays 3, then one NT leaves it at 2 (still taken)
    upd(32'h100, 1'b1, 32'h240);
    upd(32'h100, 1'b1, 32'h240);
    upd(32'h100, 1'b0, 32'h0);
    look(32'h100);
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b1, 1'b1, 32'h240}) begin
      bad++; $display("FAIL ctr_sat_high: got hit=%0b taken=%0b tgt=%h want 1 1 00000240", predict_hit, predict_taken, predict_target);
    end
  endtask

  task automatic test_lru_evict();
    logic [31:0] pc;
    logic        exp_hit;
    logic [31:0] exp_tgt;
    do_reset();
    for (int k = 0; k < 9; k++) upd(32'h1000 + 32'(k * 4), 1'b1, 32'h8000 + 32'(k * 16));
    for (int k = 0; k < 9; k++) begin
      pc      = 32'h1000 + 32'(k * 4);
      exp_hit = (k != 0);
      exp_tgt = exp_hit ? 32'h8000 + 32'(k * 16) : pc + 32'd4;
      look(pc);
      total++;
      if ({predict_hit, predict_taken, predict_target} !== {exp_hit, exp_hit, exp_tgt}) begin
        bad++; $display("FAIL evict_pc_%h: got hit=%0b taken=%0b tgt=%h want %0b %0b %h", pc, predict_hit, predict_taken, predict_target, exp_hit, exp_hit, exp_tgt);
      end
    end
  endtask

  task automatic test_lru_refresh();
    do_reset();
    for (int k = 0; k < 8; k++) upd(32'h1000 + 32'(k * 4), 1'b1, 32'h8000 + 32'(k * 16));
    upd(32'h1000, 1'b1, 32'h8000);     // touch oldest line, line of 0x1004 becomes LRU
    upd(32'h2000, 1'b1, 32'h9000);
    look(32'h1004);
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b0, 1'b0, 32'h1008}) begin
      bad++; $display("FAIL refresh_evicted: got hit=%0b taken=%0b tgt=%h want 0 0 00001008", predict_hit, predict_taken, predict_target);
    end
    look(32'h1000);
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b1, 1'b1, 32'h8000}) begin
      bad++; $display("FAIL refresh_kept: got hit=%0b taken=%0b tgt=%h want 1 1 00008000", predict_hit, predict_taken, predict_target);
    end
    look(32'h2000);
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b1, 1'b1, 32'h9000}) begin
      bad++; $display("FAIL refresh_new: got hit=%0b taken=%0b tgt=%h want 1 1 00009000", predict_hit, predict_taken, predict_target);
    end
  endtask

  task automatic test_nt_miss();
    do_reset();
    for (int k = 0; k < 8; k++) upd(32'h1000 + 32'(k * 4), 1'b1, 32'h8000 + 32'(k * 16));
    upd(32'h300, 1'b0, 32'h700);
    look(32'h300);
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b0, 1'b0, 32'h304}) begin
      bad++; $display("FAIL nt_miss_lookup: got hit=%0b taken=%0b tgt=%h want 0 0 00000304", predict_hit, predict_taken, predict_target);
    end
    // LRU untouched: next allocation still evicts 0x1000
    upd(32'h2000, 1'b1, 32'h9000);
    look(32'h1000);
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b0, 1'b0, 32'h1004}) begin
      bad++; $display("FAIL nt_miss_lru_victim: got hit=%0b taken=%0b tgt=%h want 0 0 00001004", predict_hit, predict_taken, predict_target);
    end
    look(32'h1004);
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b1, 1'b1, 32'h8010}) begin
      bad++; $display("FAIL nt_miss_lru_kept: got hit=%0b taken=%0b tgt=%h want 1 1 00008010", predict_hit, predict_taken, predict_target);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lookup_pc = 32'h400;
    update_en = 1'b1; update_pc = 32'h400; update_taken = 1'b1; update_target = 32'h480;
    #1;
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b0, 1'b0, 32'h404}) begin
      bad++; $display("FAIL same_cycle_miss: got hit=%0b taken=%0b tgt=%h want 0 0 00000404", predict_hit, predict_taken, predict_target);
    end
    @(posedge clk); #1;
    update_en = 1'b0;
    #1;
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b1, 1'b1, 32'h480}) begin
      bad++; $display("FAIL next_cycle_hit: got hit=%0b taken=%0b tgt=%h want 1 1 00000480", predict_hit, predict_taken, predict_target);
    end
  endtask

  task automatic test_enable_gate();
    // state: 0x400 cached with counter 2 from previous scenario
    en = 1'b0;
    upd(32'h600, 1'b1, 32'h680);
    upd(32'h400, 1'b0, 32'h0);
    en = 1'b1;
    look(32'h600);
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b0, 1'b0, 32'h604}) begin
      bad++; $display("FAIL en0_no_alloc: got hit=%0b taken=%0b tgt=%h want 0 0 00000604", predict_hit, predict_taken, predict_target);
    end
    look(32'h400);
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b1, 1'b1, 32'h480}) begin
      bad++; $display("FAIL en0_no_train: got hit=%0b taken=%0b tgt=%h want 1 1 00000480", predict_hit, predict_taken, predict_target);
    end
    // update_en low with en high also changes nothing
    update_pc = 32'h400; update_taken = 1'b0; update_en = 1'b0;
    @(posedge clk); #1;
    look(32'h400);
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b1, 1'b1, 32'h480}) begin
      bad++; $display("FAIL upd_en0_no_train: got hit=%0b taken=%0b tgt=%h want 1 1 00000480", predict_hit, predict_taken, predict_target);
    end
  endtask

  task automatic test_rst_override();
    rst = 1'b1; update_en = 1'b1; update_pc = 32'h500; update_taken = 1'b1; update_target = 32'h580;
    @(posedge clk); #1;
    rst = 1'b0; update_en = 1'b0;
    look(32'h400);
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b0, 1'b0, 32'h404}) begin
      bad++; $display("FAIL rst_clears_line: got hit=%0b taken=%0b tgt=%h want 0 0 00000404", predict_hit, predict_taken, predict_target);
    end
    look(32'h500);
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {1'b0, 1'b0, 32'h504}) begin
      bad++; $display("FAIL rst_beats_update: got hit=%0b taken=%0b tgt=%h want 0 0 00000504", predict_hit, predict_taken, predict_target);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0; bad = 0;
    rst = 1'b1; en = 1'b1; lookup_pc = '0;
    update_en = 1'b0; update_pc = '0; update_taken = 1'b0; update_target = '0;
    @(posedge clk); #1;
    test_reset();
    test_counter();
    test_lru_evict();
    test_lru_refresh();
    test_nt_miss();
    test_back_to_back();
    test_enable_gate();
    test_rst_override();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
